// File: rtl/tank_sensor_model.sv
// Tank plant model for closing the loop with the pump controller: integrates
// pump fill and periodic drain into a level and derives debounced I/S sensors.

module tank_debounce #(
  parameter int DLY = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_q
);
  localparam int CW = (DLY > 1) ? $clog2(DLY) : 1;
  localparam logic [CW-1:0] LAST = CW'(DLY - 1);

  logic [CW-1:0] r_cnt;
  logic          r_q;

  // Any reversion of the raw condition before the count completes restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (i_raw == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_q   <= i_raw;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q = r_q;
endmodule

module tank_sensor_model #(
  parameter int LEVEL_W      = 8,
  parameter int LEVEL_MAX    = 200,
  parameter int LOW_TH       = 50,
  parameter int HIGH_TH      = 150,
  parameter int FILL_RATE    = 2,
  parameter int DRAIN_RATE   = 3,
  parameter int DRAIN_PERIOD = 4,
  parameter int SENSOR_DLY   = 3,
  parameter int INIT_LEVEL   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               B1,
  input  logic               B2,
  input  logic               drain_en,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_val,
  input  logic [1:0]         fault,
  input  logic               clr_flags,
  output logic               I,
  output logic               S,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               underflow
);
  localparam int CW  = LEVEL_W + 2;
  localparam int DCW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

  localparam logic [LEVEL_W-1:0]   LMAX   = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0]   LOW_L  = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0]   HIGH_L = LEVEL_W'(HIGH_TH);
  localparam logic [LEVEL_W-1:0]   INIT_L = LEVEL_W'(INIT_LEVEL);
  localparam logic signed [CW-1:0] LMAX_S  = CW'(LEVEL_MAX);
  localparam logic signed [CW-1:0] FILL_S  = CW'(FILL_RATE);
  localparam logic signed [CW-1:0] DRAIN_S = CW'(DRAIN_RATE);
  localparam logic [DCW-1:0]       DLAST   = DCW'(DRAIN_PERIOD - 1);

  logic [LEVEL_W-1:0]   r_level;
  logic [DCW-1:0]       r_dcnt;
  logic                 r_ovf, r_unf;
  logic                 w_drain_evt;
  logic signed [CW-1:0] w_ext, w_fill, w_next;
  logic                 w_hi, w_lo;
  logic [LEVEL_W-1:0]   w_load;
  logic [1:0]           w_raw, w_db;

  assign w_drain_evt = drain_en && (r_dcnt == DLAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_dcnt <= '0;
    else if (!drain_en)   r_dcnt <= '0;
    else if (w_drain_evt) r_dcnt <= '0;
    else                  r_dcnt <= r_dcnt + 1'b1;
  end

  // Fill and drain net out in a wider signed domain before any clipping.
  assign w_ext = $signed({2'b00, r_level});
  always_comb begin
    w_fill = '0;
    if (B1) w_fill = w_fill + FILL_S;
    if (B2) w_fill = w_fill + FILL_S;
    w_next = w_ext + w_fill - (w_drain_evt ? DRAIN_S : '0);
  end

  assign w_lo   = w_next[CW-1];
  assign w_hi   = !w_lo && (w_next > LMAX_S);
  assign w_load = (load_val > LMAX) ? LMAX : load_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_level <= INIT_L;
    else if (load) r_level <= w_load;
    else if (w_hi) r_level <= LMAX;
    else if (w_lo) r_level <= '0;
    else           r_level <= w_next[LEVEL_W-1:0];
  end

  // A clip in the same cycle as clr_flags leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~clr_flags) | (~load & w_hi);
      r_unf <= (r_unf & ~clr_flags) | (~load & w_lo);
    end
  end

  assign w_raw[0] = (r_level >= LOW_L);
  assign w_raw[1] = (r_level >= HIGH_L);

  for (genvar g = 0; g < 2; g++) begin : g_db
    tank_debounce #(.DLY(SENSOR_DLY)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (w_raw[g]),
      .o_q     (w_db[g])
    );
  end

  // Faults override only the outputs; debounce keeps tracking the true level.
  assign I         = w_db[0] & ~fault[0];
  assign S         = w_db[1] |  fault[1];
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_tank_sensor_model.sv
// Scoreboard bench for tank_sensor_model: a cycle model pushes expected state
// per edge, popped and compared after the edge, plus directed milestone checks.

module tb_tank_sensor_model;
  localparam int LMAX = 200, LOW = 50, HIGH = 150, FILL = 2, DRN = 3, DPER = 4, DLY = 3;

  logic       clk, reset_n, B1, B2, drain_en, load, clr_flags;
  logic [7:0] load_val, level;
  logic [1:0] fault;
  logic       I, S, overflow, underflow;

  tank_sensor_model #(
    .LEVEL_W(8), .LEVEL_MAX(200), .LOW_TH(50), .HIGH_TH(150), .FILL_RATE(2),
    .DRAIN_RATE(3), .DRAIN_PERIOD(4), .SENSOR_DLY(3), .INIT_LEVEL(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .B1(B1), .B2(B2), .drain_en(drain_en),
    .load(load), .load_val(load_val), .fault(fault), .clr_flags(clr_flags),
    .I(I), .S(S), .level(level), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int lvl; int i; int s; int ovf; int unf;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;
  int m_level, m_dcnt, m_ovf, m_unf, m_i, m_s, m_icnt, m_scnt;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_dcnt = 0; m_ovf = 0; m_unf = 0;
    m_i = 0; m_s = 0; m_icnt = 0; m_scnt = 0;
  endtask

  function automatic void deb(input int raw, inout int q, inout int cnt);
    if (raw == q) cnt = 0;
    else if (cnt == DLY - 1) begin q = raw; cnt = 0; end
    else cnt = cnt + 1;
  endfunction

  task automatic model_edge();
    int evt, nxt, hi, lo;
    deb(int'(m_level >= LOW), m_i, m_icnt);
    deb(int'(m_level >= HIGH), m_s, m_scnt);
    evt = (drain_en && m_dcnt == DPER - 1) ? 1 : 0;
    m_dcnt = (!drain_en || evt != 0) ? 0 : m_dcnt + 1;
    hi = 0; lo = 0;
    if (load) begin
      m_level = (int'(load_val) > LMAX) ? LMAX : int'(load_val);
    end else begin
      nxt = m_level + (int'(B1) + int'(B2)) * FILL - evt * DRN;
      if (nxt > LMAX) begin m_level = LMAX; hi = 1; end
      else if (nxt < 0) begin m_level = 0; lo = 1; end
      else m_level = nxt;
    end
    m_ovf = ((clr_flags ? 0 : m_ovf) != 0 || hi != 0) ? 1 : 0;
    m_unf = ((clr_flags ? 0 : m_unf) != 0 || lo != 0) ? 1 : 0;
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.lvl = m_level;
    e.i   = (m_i != 0 && !fault[0]) ? 1 : 0;
    e.s   = (m_s != 0 || fault[1]) ? 1 : 0;
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  // Inputs are stable here; the model advances and its result waits in the queue.
  task automatic step();
    exp_t e;
    model_edge();
    sb.push_back(cur_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_level", int'(level), e.lvl);
    check("sb_I", int'(I), e.i);
    check("sb_S", int'(S), e.s);
    check("sb_ovf", int'(overflow), e.ovf);
    check("sb_unf", int'(underflow), e.unf);
  endtask

  task automatic idle();
    B1 = 0; B2 = 0; drain_en = 0; load = 0; load_val = '0; clr_flags = 0; fault = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    model_reset();
    #1;
    check("rst_level", int'(level), 0);
    check("rst_IS", int'({I, S}), 0);
    check("rst_flags", int'({overflow, underflow}), 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    idle();
    reset_n = 1;
    model_reset();
    #2 reset_n = 0;
    #1;
    check("por_level", int'(level), 0);
    check("por_IS", int'({I, S}), 0);
    @(negedge clk);
    reset_n = 1;

    // Single pump fill from empty
    do_reset();
    B1 = 1;
    for (int n = 1; n <= 80; n++) begin
      step();
      if (n == 25) check("s1_lvl25", int'(level), 50);
      if (n == 27) check("s1_I_e27", int'(I), 0);
      if (n == 28) check("s1_I_e28", int'(I), 1);
      if (n == 75) check("s1_lvl75", int'(level), 150);
      if (n == 77) check("s1_S_e77", int'(S), 0);
      if (n == 78) check("s1_S_e78", int'(S), 1);
    end

    // Both pumps, overflow and clear
    do_reset();
    B1 = 1; B2 = 1;
    for (int n = 1; n <= 51; n++) begin
      step();
      if (n == 38) check("s2_lvl38", int'(level), 152);
      if (n == 40) check("s2_S_e40", int'(S), 0);
      if (n == 41) check("s2_S_e41", int'(S), 1);
      if (n == 50) check("s2_ovf_e50", int'(overflow), 0);
      if (n == 51) check("s2_ovf_e51", int'(overflow), 1);
    end
    check("s2_lvl_sat", int'(level), 200);
    B1 = 0; B2 = 0; clr_flags = 1;
    step();
    check("s2_ovf_clr", int'(overflow), 0);
    clr_flags = 0;
    B1 = 1; clr_flags = 1;
    step();
    check("s2_set_wins", int'(overflow), 1);
    idle();

    // Drain timing, load clamp, underflow
    load = 1; load_val = 8'd255;
    step();
    check("s3_clamp", int'(level), 200);
    load_val = 8'd200;
    step();
    load = 0; drain_en = 1;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 3) check("s3_lvl_e3", int'(level), 200);
      if (n == 4) check("s3_lvl_e4", int'(level), 197);
      if (n == 8) check("s3_lvl_e8", int'(level), 194);
    end
    drain_en = 0; load = 1; load_val = 8'd2;
    step();
    load = 0; drain_en = 1;
    for (int n = 1; n <= 4; n++) step();
    check("s3_unf_lvl", int'(level), 0);
    check("s3_unf", int'(underflow), 1);
    idle();
    step();

    // Debounce glitch
    do_reset();
    load = 1; load_val = 8'd50;
    step();
    load_val = 8'd49;
    step();
    load = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      check("s4_glitch_I", int'(I), 0);
    end
    load = 1; load_val = 8'd50;
    step();
    for (int n = 1; n <= 3; n++) begin
      step();
      if (n == 2) check("s4_I_e2", int'(I), 0);
      if (n == 3) check("s4_I_e3", int'(I), 1);
    end
    idle();

    // Fault injection overrides outputs instantly
    load = 1; load_val = 8'd100;
    step();
    load = 0;
    for (int n = 1; n <= 4; n++) step();
    check("s5_pre_IS", int'({I, S}), 2'b10);
    fault = 2'b11;
    #1;
    check("s5_fault_I", int'(I), 0);
    check("s5_fault_S", int'(S), 1);
    for (int n = 1; n <= 3; n++) step();
    fault = 2'b00;
    #1;
    check("s5_clear_I", int'(I), 1);
    check("s5_clear_S", int'(S), 0);

    // Asynchronous reset mid-fill
    do_reset();
    B1 = 1;
    for (int n = 1; n <= 60; n++) step();
    check("s6_lvl120", int'(level), 120);
    #2;
    reset_n = 0;
    model_reset();
    #1;
    check("s6_async_lvl", int'(level), 0);
    check("s6_async_IS", int'({I, S}), 0);
    check("s6_async_ovf", int'(overflow), 0);
    @(negedge clk);
    reset_n = 1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 25) check("s6_lvl25", int'(level), 50);
      if (n == 28) check("s6_I_e28", int'(I), 1);
    end

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tank_sensor_model.md
Name: tank_sensor_model

Overview:
- Behavioural/synthesizable model of the tank that the pump controller drives: consumes pump commands B1/B2, integrates a water level, and produces the lower/upper level sensor signals I and S.
- Closes the loop on the bench and on the FPGA demo board with the controller: the controller's outputs are this block's inputs, and this block's I/S feed the controller.
- Includes periodic consumption drain, sensor debounce/settling delay, saturation flags, and a sensor fault-injection hook.

Parameters:
- LEVEL_W, 8, width of the level register.
- LEVEL_MAX, 200, full-tank level; level saturates here.
- LOW_TH, 50, level at or above which the lower sensor is wet.
- HIGH_TH, 150, level at or above which the upper sensor is wet (HIGH_TH > LOW_TH).
- FILL_RATE, 2, level units added per cycle per running pump.
- DRAIN_RATE, 3, level units removed per drain event.
- DRAIN_PERIOD, 4, cycles between drain events while drain_en = 1 (>= 1).
- SENSOR_DLY, 3, consecutive cycles a raw sensor condition must persist before I/S change (>= 1).
- INIT_LEVEL, 0, level loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- B1  in  1  pump 1 running.
- B2  in  1  pump 2 running.
- drain_en  in  1  consumption active.
- load  in  1  synchronous level load strobe (bench/demo use).
- load_val  in  LEVEL_W  value for load; values above LEVEL_MAX are clamped to LEVEL_MAX.
- fault  in  2  bit0: force I = 0 (stuck dry); bit1: force S = 1 (stuck wet).
- clr_flags  in  1  clears the sticky flags.
- I  out  1  lower sensor, debounced.
- S  out  1  upper sensor, debounced.
- level  out  LEVEL_W  current level register.
- overflow  out  1  sticky: a fill was clipped at LEVEL_MAX.
- underflow  out  1  sticky: a drain was clipped at 0.

Behaviour:
- Reset (async, reset_n = 0):
  - level = INIT_LEVEL; I = 0; S = 0; overflow = 0; underflow = 0.
  - Drain counter = 0; both debounce counters = 0.
  - Outputs take these values immediately, without waiting for clk.
- Level update on each rising edge, priority order:
  - load = 1: level <= min(load_val, LEVEL_MAX). Fill and drain are ignored that cycle. The drain counter still advances normally.
  - Otherwise: next = level + (B1 + B2) * FILL_RATE - (drain_evt ? DRAIN_RATE : 0).
  - The computation uses a signed width of LEVEL_W + 2 bits.
  - next > LEVEL_MAX: level <= LEVEL_MAX and overflow <= 1.
  - next < 0: level <= 0 and underflow <= 1.
  - Otherwise level <= next.
  - Fill and drain in the same cycle net out before saturation; a flag is set only if the net result clips.
- Drain counter:
  - drain_en = 0: counter held at 0 and drain_evt = 0.
  - drain_en = 1: drain_evt = 1 when counter == DRAIN_PERIOD - 1. The counter counts 0..DRAIN_PERIOD-1 and wraps.
  - The first drain therefore occurs on the DRAIN_PERIOD-th edge after drain_en rises.
- Flags:
  - clr_flags clears both flags.
  - If clr_flags and a new clip occur in the same cycle, set wins.
- Sensor debounce, per sensor, independent:
  - raw_I = (level >= LOW_TH); raw_S = (level >= HIGH_TH), evaluated on the registered level.
  - If raw equals the output: counter <= 0.
  - Else if counter == SENSOR_DLY - 1: output <= raw and counter <= 0.
  - Else: counter++.
  - Net effect: a crossing registered at edge k changes the output at edge k + SENSOR_DLY, provided raw stays different throughout. Any reversion earlier restarts the count.
- Fault injection:
  - Applied after the debounce register: I = I_reg & ~fault[0]; S = S_reg | fault[1].
  - Combinational, zero latency.
  - Debounce state keeps tracking the real level, so removing the fault restores the true value instantly.
- Physically inconsistent S = 1 with I = 0 arises only via fault injection; the block does not correct it.

Test Plan:
- Reset release, INIT_LEVEL = 0, B1 = 1, B2 = 0, drain_en = 0 -> level = 2n after n edges; level = 50 at edge 25; I rises at edge 28; S stays 0 until level reaches 150 (edge 75), then S rises at edge 78.
- B1 = B2 = 1 from level 0 -> level = 152 at edge 38, S rises at edge 41; level = 200 at edge 50; edge 51 -> level stays 200, overflow = 1; clr_flags one cycle with pumps off -> overflow = 0.
- load 200, then pumps off, drain_en = 1 -> level 197 at the 4th edge, 194 at the 8th; from load 2 the first drain gives level 0 and underflow = 1.
- Debounce glitch: load 50, next cycle load 49, hold -> I never rises. load 50 held for 3 edges -> I = 1 on the 3rd edge after the load edge.
- Fault: level 100 (I = 1, S = 0), fault = 2'b11 -> I = 0 and S = 1 in the same cycle; fault = 0 -> I = 1, S = 0 immediately.
- reset_n pulled low mid-fill at level 120 between clock edges -> level = 0 and I = S = overflow = 0 before the next edge; after release, behaviour restarts as in the first scenario.
